// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and requester encoding for the writeback scheduler
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// rtl/wb_rr_arb2.sv - two-requester round-robin arbiter for the register file write port
module wb_rr_arb2
    import cpu_pkg::*;
(
    input  logic       valid_alu_i,
    input  logic       valid_mem_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_nxt_o
);

    // gnt_o[0] = ALU, gnt_o[1] = MEM; pointer only moves on contention
    always_comb begin
        gnt_o     = 2'b00;
        ptr_nxt_o = ptr_i;
        if (valid_alu_i && valid_mem_i) begin
            gnt_o     = (ptr_i == REQ_ALU) ? 2'b01 : 2'b10;
            ptr_nxt_o = ~ptr_i;
        end else if (valid_alu_i) begin
            gnt_o = 2'b01;
        end else if (valid_mem_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register file write port scheduler with pending-write scoreboard (optional WB_FORWARD_EN)
module regfile_wb_scheduler
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              hazard,
`ifdef WB_FORWARD_EN
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    output logic [NREG-1:0]   busy,
    output logic              err_dup
);

    logic              ptr_q, ptr_d;
    logic [1:0]        gnt;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0] wr_data;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              err_dup_q, err_dup_d;
    logic              iss_live;
    logic              haz1, haz2;

    wb_rr_arb2 u_arb (
        .valid_alu_i (alu_valid),
        .valid_mem_i (mem_valid),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .ptr_nxt_o   (ptr_d)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign wr_fire   = |gnt;
    assign wr_rd     = gnt[1] ? mem_rd   : alu_rd;
    assign wr_data   = gnt[1] ? mem_data : alu_data;
    assign iss_live  = iss_valid && (iss_rd != REG_ZERO);

    // Scoreboard next state: clear on completed write, then set on issue so a new producer wins
    always_comb begin
        busy_d    = busy_q;
        err_dup_d = err_dup_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (iss_live) begin
            // A register being retired this very cycle is no longer outstanding
            if (busy_q[iss_rd] && !(rf_we_q && rf_waddr_q == iss_rd)) begin
                err_dup_d = 1'b1;
            end
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port, arbiter pointer and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= REQ_ALU;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
            err_dup_q  <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rf_we_q   <= wr_fire && (wr_rd != REG_ZERO);
            busy_q    <= busy_d;
            err_dup_q <= err_dup_d;
            // Writes to r0 are swallowed and leave the address/data outputs untouched
            if (wr_fire && (wr_rd != REG_ZERO)) begin
                rf_waddr_q <= wr_rd;
                rf_wdata_q <= wr_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;
    assign err_dup  = err_dup_q;

    assign haz1 = (chk_rs1 != REG_ZERO) && busy_q[chk_rs1];
    assign haz2 = (chk_rs2 != REG_ZERO) && busy_q[chk_rs2];

`ifdef WB_FORWARD_EN
    // A source being written this cycle is served from the write port instead of stalling
    assign fwd_hit1  = rf_we_q && (rf_waddr_q == chk_rs1) && (chk_rs1 != REG_ZERO);
    assign fwd_hit2  = rf_we_q && (rf_waddr_q == chk_rs2) && (chk_rs2 != REG_ZERO);
    assign fwd_data1 = rf_wdata_q;
    assign fwd_data2 = rf_wdata_q;
    assign hazard    = (haz1 && !fwd_hit1) || (haz2 && !fwd_hit2);
`else
    assign hazard    = haz1 || haz2;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_rs1, chk_rs2;
    logic        hazard;
    logic [31:0] busy;
    logic        err_dup;
`ifdef WB_FORWARD_EN
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .hazard    (hazard),
`ifdef WB_FORWARD_EN
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
`endif
        .busy      (busy),
        .err_dup   (err_dup)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wb_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write-port pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got addr=%0d data=%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    bad++;
                    $display("FAIL wb_write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        iss_valid = 0; iss_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        chk_rs1 = 0; chk_rs2 = 0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_dup, 0);
        chk("rst_hazard", hazard, 0);
        chk("idle_alu_ready", alu_ready, 0);
        chk("idle_mem_ready", mem_ready, 0);
        step();
        rst_n = 1'b1;

        // Issue r5, hazard, ALU writeback, clear
        step(); iss_valid = 1; iss_rd = 5;
        step(); iss_valid = 0; chk_rs1 = 5;
        @(negedge clk);
        chk("haz_r5", hazard, 1);
        chk("busy_r5", busy, 32'h20);
        step(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        push(5, 32'hDEADBEEF);
        @(negedge clk);
        chk("alu_ready_single", alu_ready, 1);
        chk("mem_ready_single", mem_ready, 0);
        step(); alu_valid = 0;
        @(negedge clk);
        chk("we_r5", rf_we, 1);
`ifdef WB_FORWARD_EN
        chk("haz_r5_fwd", hazard, 0);
`else
        chk("haz_r5_wr", hazard, 1);
`endif
        step();
        @(negedge clk);
        chk("busy_r5_clr", busy, 0);
        chk("haz_r5_clr", hazard, 0);
        chk("we_r5_done", rf_we, 0);
        chk_rs1 = 0;

        // Contention: grants alternate ALU, MEM, ALU, MEM
        step();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33333333;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h44444444;
        push(3, 32'h33333333); push(4, 32'h44444444);
        push(3, 32'h33333333); push(4, 32'h44444444);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_alu_ready", alu_ready, (i % 2 == 0));
            chk("rr_mem_ready", mem_ready, (i % 2 == 1));
            if (i > 0) chk("rr_we", rf_we, 1);
            step();
        end
        alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        chk("rr_we_last", rf_we, 1);
        step();
        @(negedge clk);
        chk("rr_we_end", rf_we, 0);

        // Write to r0 and issue to r0
        step(); mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
        @(negedge clk);
        chk("r0_mem_ready", mem_ready, 1);
        chk("r0_alu_ready", alu_ready, 0);
        step(); mem_valid = 0; iss_valid = 1; iss_rd = 0;
        @(negedge clk);
        chk("r0_we", rf_we, 0);
        chk("r0_waddr_hold", rf_waddr, 4);
        chk("r0_wdata_hold", rf_wdata, 32'h44444444);
        step(); iss_valid = 0;
        @(negedge clk);
        chk("r0_busy", busy, 0);

        // Set beats clear on r7, then a real duplicate issue
        step(); iss_valid = 1; iss_rd = 7;
        step(); iss_valid = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        push(7, 32'h77);
        @(negedge clk);
        chk("r7_alu_ready", alu_ready, 1);
        step(); alu_valid = 0; iss_valid = 1; iss_rd = 7;
        @(negedge clk);
        chk("r7_we", rf_we, 1);
        step();
        @(negedge clk);
        chk("r7_busy_kept", busy, 32'h80);
        chk("r7_no_dup", err_dup, 0);
        step(); iss_valid = 0; chk_rs2 = 7;
        @(negedge clk);
        chk("r7_dup", err_dup, 1);
        chk("r7_haz", hazard, 1);
        step(); step();
        @(negedge clk);
        chk("r7_dup_sticky", err_dup, 1);

        // Same-cycle read of a register being written (r9)
        step(); chk_rs2 = 0; iss_valid = 1; iss_rd = 9;
        step(); iss_valid = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'hA5A5A5A5;
        push(9, 32'hA5A5A5A5);
        step(); alu_valid = 0; chk_rs2 = 9;
        @(negedge clk);
`ifdef WB_FORWARD_EN
        chk("fwd_hit2", fwd_hit2, 1);
        chk("fwd_data2", fwd_data2, 32'hA5A5A5A5);
        chk("fwd_hit1", fwd_hit1, 0);
        chk("fwd_haz", hazard, 0);
`else
        chk("r9_haz", hazard, 1);
`endif
        step(); chk_rs2 = 0;

        // Reset mid-burst
        step();
        alu_valid = 1; alu_rd = 10; alu_data = 32'hAAAA;
        mem_valid = 1; mem_rd = 11; mem_data = 32'hBBBB;
        iss_valid = 1; iss_rd = 12;
        push(10, 32'hAAAA);
        step(); iss_valid = 0;
        @(negedge clk);
        chk("burst_we", rf_we, 1);
        #1;
        rst_n = 0; alu_valid = 0; mem_valid = 0;
        #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_waddr", rf_waddr, 0);
        chk("mid_rst_wdata", rf_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_dup, 0);
        chk("mid_rst_haz", hazard, 0);
        chk("mid_rst_ready", {alu_ready, mem_ready}, 0);
        step(); step();
        rst_n = 1;
        step(); step();
        @(negedge clk);
        chk("post_rst_we", rf_we, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
